// File: rtl/hub75_scan_if.sv
`default_nettype none
// =============================================================================
// Module   : hub75_scan_if
// Brief    : Handshake bundle between the HUB75 row scan sequencer, the
//            line-buffer filler, the BCM row controller and the framebuffer.
// Revision : 1.0 - initial release
// =============================================================================
interface hub75_scan_if #(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) ();
    logic                  ctrl_run;
    logic [LOG_N_ROWS-1:0] fill_row;
    logic                  fill_go;
    logic                  fill_rdy;
    logic                  buf_swap;
    logic [LOG_N_ROWS-1:0] bcm_row;
    logic                  bcm_go;
    logic                  bcm_rdy;
    logic                  frame_swap;
    logic                  frame_swap_ack;
    logic [7:0]            frame_cnt;
    logic                  busy;

    // The scan sequencer side.
    modport master (
        input  ctrl_run,
        input  fill_rdy,
        input  bcm_rdy,
        input  frame_swap_ack,
        output fill_row,
        output fill_go,
        output buf_swap,
        output bcm_row,
        output bcm_go,
        output frame_swap,
        output frame_cnt,
        output busy
    );

    // The filler / BCM / framebuffer side.
    modport slave (
        output ctrl_run,
        output fill_rdy,
        output bcm_rdy,
        output frame_swap_ack,
        input  fill_row,
        input  fill_go,
        input  buf_swap,
        input  bcm_row,
        input  bcm_go,
        input  frame_swap,
        input  frame_cnt,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/hub75_scan.sv
`default_nettype none
// =============================================================================
// Module   : hub75_scan
// Brief    : HUB75 row scan sequencer; keeps the back line buffer filled one
//            row ahead of the BCM driver. Optional macro
//            HUB75_SCAN_FRAME_SYNC_EN parks FRAME_END until frame_swap_ack.
// Revision : 1.0 - initial release
// =============================================================================
module hub75_scan #(
    parameter int N_ROWS     = 32,
    parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
    input  logic         clk,
    input  logic         rst_n,
    hub75_scan_if.master bus
);

    if (N_ROWS < 2 || (N_ROWS & (N_ROWS - 1)) != 0) begin : g_param_check
        $error("hub75_scan: N_ROWS must be a power of two and at least 2");
    end

    localparam logic [LOG_N_ROWS-1:0] c_last_row = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_ROWS-1:0] c_row_one  = LOG_N_ROWS'(1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL_ISSUE = 3'd1,
        S_WAIT       = 3'd2,
        S_SWAP       = 3'd3,
        S_FRAME_END  = 3'd4,
        S_DRAIN      = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LOG_N_ROWS-1:0] r_row_fill;
    logic [LOG_N_ROWS-1:0] w_row_fill_nxt;
    logic [LOG_N_ROWS-1:0] r_fill_row;
    logic [LOG_N_ROWS-1:0] r_bcm_row;
    logic [7:0]            r_frame_cnt;
    logic                  r_frame_swap;
    logic                  w_frame_exit;

`ifdef HUB75_SCAN_FRAME_SYNC_EN
    assign w_frame_exit = bus.frame_swap_ack;
`else
    logic w_unused_ack;
    assign w_unused_ack = bus.frame_swap_ack;
    assign w_frame_exit = 1'b1;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_row_fill_nxt = r_row_fill;
        case (r_state)
            S_IDLE: begin
                w_row_fill_nxt = '0;
                if (bus.ctrl_run) begin
                    w_state_nxt = S_FILL_ISSUE;
                end
            end
            S_FILL_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Join point: filler and BCM may become idle in different cycles.
                if (bus.fill_rdy && bus.bcm_rdy) begin
                    w_state_nxt = S_SWAP;
                end
            end
            S_SWAP: begin
                w_row_fill_nxt = r_row_fill + c_row_one;
                w_state_nxt    = (r_row_fill == c_last_row) ? S_FRAME_END : S_FILL_ISSUE;
            end
            S_FRAME_END: begin
                if (w_frame_exit) begin
                    w_state_nxt = bus.ctrl_run ? S_FILL_ISSUE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.bcm_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row addresses are captured on entry to the issuing state so they stay
    // put between pulses instead of following the running row counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_fill   <= '0;
            r_fill_row   <= '0;
            r_bcm_row    <= '0;
            r_frame_cnt  <= 8'd0;
            r_frame_swap <= 1'b0;
        end else begin
            r_row_fill   <= w_row_fill_nxt;
            r_frame_swap <= (w_state_nxt == S_FRAME_END) && (r_state != S_FRAME_END);
            if (w_state_nxt == S_FILL_ISSUE) begin
                r_fill_row <= w_row_fill_nxt;
            end
            if (w_state_nxt == S_SWAP) begin
                r_bcm_row <= r_row_fill;
            end
            if ((r_state == S_FRAME_END) && w_frame_exit) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.fill_row   = r_fill_row;
    assign bus.fill_go    = (r_state == S_FILL_ISSUE);
    assign bus.buf_swap   = (r_state == S_SWAP);
    assign bus.bcm_row    = r_bcm_row;
    assign bus.bcm_go     = (r_state == S_SWAP);
    assign bus.frame_swap = r_frame_swap;
    assign bus.frame_cnt  = r_frame_cnt;
    assign bus.busy       = (r_state != S_IDLE);

    a_swap_with_go : assert property (@(posedge clk) disable iff (!rst_n)
        bus.buf_swap == bus.bcm_go);

    a_go_needs_both_ready : assert property (@(posedge clk) disable iff (!rst_n)
        ((r_state == S_WAIT) && !(bus.fill_rdy && bus.bcm_rdy)) |=> !bus.bcm_go);

    a_frame_swap_single : assert property (@(posedge clk) disable iff (!rst_n)
        bus.frame_swap |=> !bus.frame_swap);

    a_bcm_row_stable : assert property (@(posedge clk) disable iff (!rst_n)
        !bus.bcm_go |-> $stable(bus.bcm_row));

endmodule
`default_nettype wire
